// File: rtl/unary_add_pkg.sv
// Shared types and constants for the radix-5 unary adder sequencer.
// Digits are 3-bit binary values 0..4; each phase lasts five cycles.
package unary_add_pkg;
  localparam int DIGIT_W   = 3;
  localparam int RADIX     = 5;
  localparam int PHASE_LEN = 5;
  localparam int PHASE_W   = 3;
  localparam logic [DIGIT_W-1:0] MAX_DIGIT = DIGIT_W'(RADIX - 1);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } state_e;
endpackage

// File: rtl/unary_pulse_gen.sv
// Thermometer encoder for one digit: pulse is high while k < value.
// Out-of-range digits are clamped to the largest legal digit.
module unary_pulse_gen
  import unary_add_pkg::*;
(
  input  logic [DIGIT_W-1:0] value_i,
  input  logic [PHASE_W-1:0] k_i,
  output logic               pulse_o,
  output logic [DIGIT_W-1:0] clamp_o,
  output logic               err_o
);
  assign err_o   = value_i > MAX_DIGIT;
  assign clamp_o = err_o ? MAX_DIGIT : value_i;
  assign pulse_o = k_i < PHASE_W'(clamp_o);
endmodule

// File: rtl/unary_add_seq.sv
// Digit-serial sequencer driving one radix-5 unary adder slice.
// Feeds unary pulses, ripples carry, counts dout pulses into digits.
module unary_add_seq
  import unary_add_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [DIGIT_W*DIGITS-1:0] a_digits,
  input  logic [DIGIT_W*DIGITS-1:0] b_digits,
  output logic                      busy,
  output logic                      done,
  output logic [DIGIT_W*DIGITS-1:0] sum_digits,
  output logic                      carry_out,
  output logic                      input_err,
  output logic                      add_A,
  output logic                      add_B,
  output logic                      add_en,
  output logic                      add_rw,
  input  logic                      add_dout,
  input  logic                      add_C
);
  localparam int W  = DIGIT_W * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PHASE_W-1:0] K_LAST = PHASE_W'(PHASE_LEN - 1);
  localparam logic [IW-1:0] D_LAST = IW'(DIGITS - 1);

  state_e state_q, state_d;
  logic [PHASE_W-1:0] k_q, k_d;
  logic [IW-1:0] d_q, d_d, d_prev, ci;
  logic [W-1:0] a_q, a_d, b_q, b_d;
  logic [W-1:0] sum_q, sum_d;
  logic [W-1:0] a_src, b_src, a_clp, b_clp;
  logic [DIGITS-1:0] a_pul, b_pul, a_err, b_err;
  logic cout_q, cout_d, err_q, err_d;
  logic cin_q, cin_d, cap_q, cap_d;
  logic [DIGIT_W-1:0] ones_q, ones_d, ones_fin;
  logic k_last, commit;

  // Clamp/error on live inputs while idle, pulses on latched ones after.
  assign a_src = (state_q == IDLE) ? a_digits : a_q;
  assign b_src = (state_q == IDLE) ? b_digits : b_q;

  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    unary_pulse_gen u_a (
      .value_i(a_src[DIGIT_W*i +: DIGIT_W]),
      .k_i    (k_q),
      .pulse_o(a_pul[i]),
      .clamp_o(a_clp[DIGIT_W*i +: DIGIT_W]),
      .err_o  (a_err[i])
    );
    unary_pulse_gen u_b (
      .value_i(b_src[DIGIT_W*i +: DIGIT_W]),
      .k_i    (k_q),
      .pulse_o(b_pul[i]),
      .clamp_o(b_clp[DIGIT_W*i +: DIGIT_W]),
      .err_o  (b_err[i])
    );
  end

  assign k_last   = (k_q == K_LAST);
  assign d_prev   = d_q - 1'b1;
  assign ones_fin = ones_q + DIGIT_W'(add_dout);

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    d_d     = d_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    err_d   = err_q;
    cin_d   = cin_q;
    cap_d   = cap_q;
    ones_d  = ones_q;
    commit  = 1'b0;
    ci      = d_q;
    add_A   = 1'b0;
    add_B   = 1'b0;
    add_en  = 1'b0;
    add_rw  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a_clp;
          b_d     = b_clp;
          err_d   = |{a_err, b_err};
          sum_d   = '0;
          cout_d  = 1'b0;
          cin_d   = 1'b0;
          cap_d   = 1'b0;
          ones_d  = '0;
          d_d     = '0;
          k_d     = '0;
          state_d = READ;
        end
      end
      READ: begin
        add_en = 1'b1;
        add_A  = k_last ? cin_q : a_pul[d_q];
        add_B  = k_last ? 1'b0 : b_pul[d_q];
        if (k_q == '0) begin
          // Last dout sample of the previous digit lands here.
          if (d_q != '0) begin
            commit = 1'b1;
            ci     = d_prev;
            cin_d  = cap_q;
            cap_d  = 1'b0;
            ones_d = '0;
          end
        end else begin
          cap_d = cap_q | add_C;
        end
        k_d = k_q + 1'b1;
        if (k_last) begin
          k_d     = '0;
          state_d = WRITE;
        end
      end
      WRITE: begin
        add_en = 1'b1;
        add_rw = 1'b1;
        if (k_q == '0) cap_d = cap_q | add_C;
        else ones_d = ones_fin;
        k_d = k_q + 1'b1;
        if (k_last) begin
          k_d = '0;
          if (d_q == D_LAST) begin
            state_d = DONE;
          end else begin
            d_d     = d_q + 1'b1;
            state_d = READ;
          end
        end
      end
      DONE: begin
        commit  = 1'b1;
        cout_d  = cap_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (commit) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (IW'(i) == ci) sum_d[DIGIT_W*i +: DIGIT_W] = ones_fin;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      d_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
      cin_q   <= 1'b0;
      cap_q   <= 1'b0;
      ones_q  <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      d_q     <= d_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      err_q   <= err_d;
      cin_q   <= cin_d;
      cap_q   <= cap_d;
      ones_q  <= ones_d;
    end
  end

  // The final digit is committed in DONE, so bypass it to the outputs.
  assign busy       = (state_q == READ) || (state_q == WRITE);
  assign done       = (state_q == DONE);
  assign sum_digits = (state_q == DONE) ? sum_d : sum_q;
  assign carry_out  = (state_q == DONE) ? cout_d : cout_q;
  assign input_err  = err_q;
endmodule

// File: tb/tb_unary_add_seq.sv
// Bench for unary_add_seq with a behavioural radix-5 unary slice.
// Results are checked against plain base-5 integer addition.
module tb_unary_add_seq;
  localparam int DIGITS = 4;
  localparam int W = 3 * DIGITS;
  localparam int DONE_AT = 10 * DIGITS + 1;

  logic clk = 0;
  logic rst_n = 0;
  logic start = 0;
  logic [W-1:0] a_digits = '0;
  logic [W-1:0] b_digits = '0;
  logic busy, done, carry_out, input_err;
  logic [W-1:0] sum_digits;
  logic add_A, add_B, add_en, add_rw, add_dout, add_C;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  unary_add_seq #(.DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a_digits  (a_digits),
    .b_digits  (b_digits),
    .busy      (busy),
    .done      (done),
    .sum_digits(sum_digits),
    .carry_out (carry_out),
    .input_err (input_err),
    .add_A     (add_A),
    .add_B     (add_B),
    .add_en    (add_en),
    .add_rw    (add_rw),
    .add_dout  (add_dout),
    .add_C     (add_C)
  );

  // Slice: read adds A+B mod 5 with registered carry;
  // write emits one registered dout pulse per count unit.
  int s_cnt;
  logic s_dout, s_c;
  assign add_dout = s_dout;
  assign add_C    = s_c;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_cnt  <= 0;
      s_dout <= 1'b0;
      s_c    <= 1'b0;
    end else if (add_en && !add_rw) begin
      if (s_cnt + int'(add_A) + int'(add_B) >= 5) begin
        s_cnt <= s_cnt + int'(add_A) + int'(add_B) - 5;
        s_c   <= 1'b1;
      end else begin
        s_cnt <= s_cnt + int'(add_A) + int'(add_B);
        s_c   <= 1'b0;
      end
      s_dout <= 1'b0;
    end else if (add_en && add_rw) begin
      s_dout <= (s_cnt > 0);
      if (s_cnt > 0) s_cnt <= s_cnt - 1;
      s_c <= 1'b0;
    end else begin
      s_dout <= 1'b0;
      s_c    <= 1'b0;
    end
  end

  function automatic logic [W-1:0] pk(input int d0, d1, d2, d3);
    logic [W-1:0] v;
    v = {3'(d3), 3'(d2), 3'(d1), 3'(d0)};
    return v;
  endfunction

  function automatic void ref_add(input logic [W-1:0] a, b,
                                  output logic [W-1:0] s,
                                  output logic c, output logic e);
    int va, vb, p, tot, da, db;
    va = 0; vb = 0; p = 1; e = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      da = int'(a[3*i +: 3]);
      db = int'(b[3*i +: 3]);
      if (da > 4) begin da = 4; e = 1'b1; end
      if (db > 4) begin db = 4; e = 1'b1; end
      va += da * p;
      vb += db * p;
      p *= 5;
    end
    tot = va + vb;
    c = (tot >= p);
    tot = tot % p;
    s = '0;
    for (int i = 0; i < DIGITS; i++) begin
      s[3*i +: 3] = 3'(tot % 5);
      tot = tot / 5;
    end
  endfunction

  logic [W-1:0] r_sum, r_sum_end;
  logic r_cout, r_cout_end, r_err, r_busy1;
  int r_done_cyc, r_done_cnt;
  int apul [DIGITS];

  task automatic run_op(input logic [W-1:0] a, b, input bit ign);
    r_done_cyc = 0;
    r_done_cnt = 0;
    r_sum = '0; r_cout = 0; r_err = 0;
    for (int i = 0; i < DIGITS; i++) apul[i] = 0;
    @(negedge clk);
    a_digits = a;
    b_digits = b;
    start = 1;
    @(posedge clk);
    #1 start = 0;
    a_digits = ~a;
    b_digits = ~b;
    for (int n = 1; n <= 55; n++) begin
      @(negedge clk);
      start = ign && (n == 5 || n == 20);
      if (n == 1) r_busy1 = busy;
      if (done === 1'b1) begin
        r_done_cnt++;
        if (r_done_cyc == 0) begin
          r_done_cyc = n;
          r_sum  = sum_digits;
          r_cout = carry_out;
          r_err  = input_err;
        end
      end
      if (n <= 40 && add_en && !add_rw && ((n - 1) % 10) < 4 && add_A)
        apul[(n - 1) / 10]++;
    end
    start = 0;
    r_sum_end  = sum_digits;
    r_cout_end = carry_out;
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (2) @(negedge clk);
    total++;
    if ({busy, done, sum_digits, carry_out, input_err,
         add_A, add_B, add_en, add_rw} !== '0) begin
      bad++;
      $display("FAIL reset_outs got %b want 0",
        {busy, done, sum_digits, carry_out, input_err,
         add_A, add_B, add_en, add_rw});
    end
    rst_n = 1;
    repeat (2) @(negedge clk);
    total++;
    if ({busy, done, add_en} !== 3'b000) begin
      bad++;
      $display("FAIL idle_after_reset got %b want 000",
        {busy, done, add_en});
    end
  endtask

  task automatic test_identity();
    int exp_p [DIGITS];
    exp_p = '{1, 2, 3, 4};
    run_op(pk(1, 2, 3, 4), '0, 0);
    total++;
    if (r_done_cyc != DONE_AT) begin
      bad++;
      $display("FAIL ident_done_cyc got %0d want %0d", r_done_cyc, DONE_AT);
    end
    total++;
    if (r_busy1 !== 1'b1) begin
      bad++;
      $display("FAIL ident_busy got %b want 1", r_busy1);
    end
    total++;
    if (r_sum !== pk(1, 2, 3, 4) || r_cout !== 1'b0) begin
      bad++;
      $display("FAIL ident_sum got %h/%b want %h/0",
        r_sum, r_cout, pk(1, 2, 3, 4));
    end
    for (int i = 0; i < DIGITS; i++) begin
      total++;
      if (apul[i] != exp_p[i]) begin
        bad++;
        $display("FAIL ident_apulse%0d got %0d want %0d",
          i, apul[i], exp_p[i]);
      end
    end
    total++;
    if (r_sum_end !== r_sum || r_done_cnt != 1) begin
      bad++;
      $display("FAIL ident_hold got %h cnt %0d want %h cnt 1",
        r_sum_end, r_done_cnt, r_sum);
    end
  endtask

  task automatic test_single_carry();
    run_op(pk(4, 0, 0, 0), pk(4, 0, 0, 0), 0);
    total++;
    if (r_sum !== pk(3, 1, 0, 0) || r_cout !== 1'b0) begin
      bad++;
      $display("FAIL single_carry got %h/%b want %h/0",
        r_sum, r_cout, pk(3, 1, 0, 0));
    end
  endtask

  task automatic test_full_ripple();
    run_op(pk(4, 4, 4, 4), pk(4, 4, 4, 4), 0);
    total++;
    if (r_sum !== pk(3, 4, 4, 4) || r_cout !== 1'b1) begin
      bad++;
      $display("FAIL ripple got %h/%b want %h/1",
        r_sum, r_cout, pk(3, 4, 4, 4));
    end
    total++;
    if (r_cout_end !== 1'b1 || r_sum_end !== pk(3, 4, 4, 4)) begin
      bad++;
      $display("FAIL ripple_hold got %h/%b want %h/1",
        r_sum_end, r_cout_end, pk(3, 4, 4, 4));
    end
  endtask

  task automatic test_clamp();
    run_op(pk(7, 0, 0, 0), '0, 0);
    total++;
    if (r_sum !== pk(4, 0, 0, 0) || r_err !== 1'b1) begin
      bad++;
      $display("FAIL clamp got %h err %b want %h err 1",
        r_sum, r_err, pk(4, 0, 0, 0));
    end
    run_op(pk(1, 1, 0, 0), pk(0, 2, 0, 0), 0);
    total++;
    if (r_err !== 1'b0 || r_sum !== pk(1, 3, 0, 0)) begin
      bad++;
      $display("FAIL clamp_clear got %h err %b want %h err 0",
        r_sum, r_err, pk(1, 3, 0, 0));
    end
  endtask

  task automatic test_ignored_start();
    run_op(pk(3, 2, 1, 0), pk(3, 3, 3, 3), 1);
    total++;
    if (r_done_cyc != DONE_AT || r_done_cnt != 1) begin
      bad++;
      $display("FAIL ign_start got cyc %0d cnt %0d want %0d cnt 1",
        r_done_cyc, r_done_cnt, DONE_AT);
    end
    total++;
    if (r_sum !== pk(1, 1, 0, 4) || r_cout !== 1'b0) begin
      bad++;
      $display("FAIL ign_sum got %h/%b want %h/0",
        r_sum, r_cout, pk(1, 1, 0, 4));
    end
  endtask

  task automatic test_reset_midop();
    @(negedge clk);
    a_digits = pk(7, 4, 4, 4);
    b_digits = pk(4, 4, 4, 4);
    start = 1;
    @(posedge clk);
    #1 start = 0;
    for (int n = 1; n <= 23; n++) @(negedge clk);
    rst_n = 0;
    #1;
    total++;
    if ({busy, done, sum_digits, carry_out, input_err,
         add_A, add_B, add_en, add_rw} !== '0) begin
      bad++;
      $display("FAIL midop_reset got %b want 0",
        {busy, done, sum_digits, carry_out, input_err,
         add_A, add_B, add_en, add_rw});
    end
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    total++;
    if ({busy, done, add_en} !== 3'b000) begin
      bad++;
      $display("FAIL midop_idle got %b want 000", {busy, done, add_en});
    end
    run_op(pk(2, 0, 0, 0), pk(2, 0, 0, 0), 0);
    total++;
    if (r_sum !== pk(4, 0, 0, 0) || r_cout !== 1'b0 ||
        r_done_cyc != DONE_AT) begin
      bad++;
      $display("FAIL midop_rerun got %h/%b cyc %0d want %h/0 cyc %0d",
        r_sum, r_cout, r_done_cyc, pk(4, 0, 0, 0), DONE_AT);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, es;
    logic ec, ee;
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < DIGITS; i++) begin
        a[3*i +: 3] = ($urandom_range(0, 9) == 0) ?
          3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
        b[3*i +: 3] = ($urandom_range(0, 9) == 0) ?
          3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      end
      ref_add(a, b, es, ec, ee);
      run_op(a, b, 0);
      total++;
      if (r_sum !== es || r_cout !== ec || r_err !== ee ||
          r_done_cyc != DONE_AT) begin
        bad++;
        $display("FAIL rand%0d a=%h b=%h got %h/%b/%b cyc %0d want %h/%b/%b",
          t, a, b, r_sum, r_cout, r_err, r_done_cyc, es, ec, ee);
      end
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_single_carry();
    test_full_ripple();
    test_clamp();
    test_ignored_start();
    test_reset_midop();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/unary_add_seq.md
Name: unary_add_seq

Overview:
- Digit-serial sequencer for one radix-5 unary adder slice. The slice takes serial unary pulse inputs A/B, has a read/write phase select, a unary dout stream and a registered carry C.
- Converts DIGITS packed binary digit pairs (LSD first) into unary pulse trains and drives the slice's en/read_or_write phases.
- Re-injects each digit's carry into the next digit, counts dout pulses back into binary sum digits and reports the final carry.
- Sits between a register-mapped operand interface and one shared adder slice instance.

Parameters:
- DIGITS, 4, number of radix-5 digits per operation (1..8).

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset (also wired to the adder slice)
- start  input  1  begin operation; sampled only in IDLE
- a_digits  input  3*DIGITS  operand A; digit i at [3i+2:3i], LSD = digit 0
- b_digits  input  3*DIGITS  operand B, same packing
- busy  output  1  high from cycle after accepted start until done
- done  output  1  one-cycle completion pulse
- sum_digits  output  3*DIGITS  result digits, each 0..4
- carry_out  output  1  carry out of the most significant digit
- input_err  output  1  sticky: some operand digit was >4 (clamped)
- add_A  output  1  slice A pulse
- add_B  output  1  slice B pulse
- add_en  output  1  slice enable
- add_rw  output  1  slice read_or_write (0 = read, 1 = write)
- add_dout  input  1  slice unary output
- add_C  input  1  slice carry

Behaviour:
- Reset values:
  - busy, done, carry_out, input_err, add_A, add_B, add_en, add_rw: 0.
  - sum_digits: 0. State: IDLE.
- States: IDLE, READ, WRITE, DONE. Internal counters: phase k (0..4) and digit index d.
- Start in IDLE:
  - Latch operands.
  - Clamp any digit >4 to 4 and set input_err (cleared only by the next accepted start).
  - Clear sum_digits and carry_out; set cin=0, d=0, k=0.
  - Go to READ. busy=1 from the next cycle.
  - start while busy or in DONE is ignored.
- READ, 5 cycles (k=0..4):
  - add_en=1, add_rw=0.
  - k<4: add_A=(k<a_d), add_B=(k<b_d). k=4: add_A=cin, add_B=0.
  - The carry register is OR of add_C sampled at READ k=1..4 and WRITE k=0, because C is registered one cycle behind. At most one carry per digit, since the maximum digit sum is 4+4+1=9.
- WRITE, 5 cycles (k=0..4):
  - add_en=1, add_rw=1, add_A=add_B=0.
  - Ones counter = number of add_dout highs sampled at WRITE k=1..4, plus one extra sample on the following cycle taken as READ k=0 of the next digit, or in DONE.
  - At that sample the controller commits sum_digits[d] = ones, sets cin = captured carry, and increments d.
- Per-digit time: 10 cycles. After the last digit's WRITE k=4, go to DONE.
- DONE, 1 cycle:
  - Final dout sample and commit.
  - carry_out = final captured carry; done=1; busy drops. Then return to IDLE.
- Latency:
  - Start sampled at edge E0; first READ cycle is cycle 1.
  - done is high in cycle 10*DIGITS+1 (41 for DIGITS=4).
  - Results valid with done and held until the next accepted start.
- Slice drain: 4 write cycles always drain the slice count to 0, so every digit starts from count 0.
- Reset mid-operation:
  - Everything returns to reset values immediately; the slice is reset by the same rst_n.
  - No partial result is retained.
  - add_en is 0 in IDLE/DONE, so the slice is frozen between operations.

Decomposition:
- Package unary_add_pkg: state enum, DIGIT_W=3, RADIX=5, PHASE_LEN=5, MAX_DIGIT=4.
- One sub-module: unary_pulse_gen (thermometer encoder: value, k -> bit k<value; clamp plus error flag).
- The adder slice itself is instantiated alongside by the integrator, not inside this block.

Test Plan:
- Identity: a=[1,2,3,4] (LSD first), b=0 -> sum=[1,2,3,4], carry_out=0, done at cycle 41, add_A pulse counts 1,2,3,4.
- Single carry: a=[4,0,0,0], b=[4,0,0,0] -> sum=[3,1,0,0], carry_out=0.
- Full ripple: a=b=[4,4,4,4] -> sum=[3,4,4,4], carry_out=1.
- Clamp: a digit0=7, b=0 -> sum digit0=4, input_err=1; next start with legal digits -> input_err=0.
- Ignored start: pulse start at cycles 5 and 20 mid-operation -> single done at 41, results unchanged.
- Reset mid-op: assert rst_n=0 at cycle 23 -> all outputs 0, state IDLE. A new start with a=[2,0,0,0], b=[2,0,0,0] -> sum=[4,0,0,0].
